// File: rtl/mem_responder.sv
// mem_responder: 16-bit word array with two independent 2-stage read pipelines
// and one write port. Reads bypass a write that lands on the in-flight address.
module mem_responder #(
  parameter int unsigned DEPTH     = 32768,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:1] raddr0,
  output logic [15:0] rdata0,
  input  logic [15:1] raddr1,
  output logic [15:0] rdata1,
  input  logic        wen,
  input  logic [15:1] waddr,
  input  logic [15:0] wdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = 16;

  // Reject array sizes that the address wrap cannot represent.
  if (DEPTH < 2 || DEPTH > 32768 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_responder: DEPTH must be a power of two in 2..32768");
  end

  logic [DW-1:0] mem [DEPTH];

  // Wrapped array indices: only the low AW address bits select a word.
  logic [AW-1:0] widx;
  logic [AW-1:0] ridx0;
  logic [AW-1:0] ridx1;

  // Stage-A address registers, one per read port.
  logic [AW-1:0] addr_a0;
  logic [AW-1:0] addr_a1;

  // Write-first bypass selects for each port's stage B.
  logic byp0_c;
  logic byp1_c;

  // Upper address bits above the array size are intentionally ignored.
  logic unused_bits;

  assign widx  = waddr[AW:1];
  assign ridx0 = raddr0[AW:1];
  assign ridx1 = raddr1[AW:1];

  assign unused_bits = ^{raddr0, raddr1, waddr};

  // A write arriving on the same edge stage B samples wins over the stale word.
  assign byp0_c = wen && (widx == addr_a0);
  assign byp1_c = wen && (widx == addr_a1);

  // Array write port; suppressed while reset is asserted, contents never cleared.
  always_ff @(posedge clk) begin
    if (rst_n && wen) begin
      mem[widx] <= wdata;
    end
  end

  // Port 0 stage A: register the wrapped fetch address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_a0 <= AW'(0);
    end else begin
      addr_a0 <= ridx0;
    end
  end

  // Port 0 stage B: register array data (or bypassed write data) for stage A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0 <= 16'(0);
    end else if (byp0_c) begin
      rdata0 <= wdata;
    end else begin
      rdata0 <= mem[addr_a0];
    end
  end

  // Port 1 stage A: register the wrapped load / second-fetch address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_a1 <= AW'(0);
    end else begin
      addr_a1 <= ridx1;
    end
  end

  // Port 1 stage B: register array data (or bypassed write data) for stage A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1 <= 16'(0);
    end else if (byp1_c) begin
      rdata1 <= wdata;
    end else begin
      rdata1 <= mem[addr_a1];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected read data with a
// due edge; a negedge monitor pops and compares against the read ports.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [15:1] raddr0;
  logic [15:0] rdata0;
  logic [15:1] raddr1;
  logic [15:0] rdata1;
  logic        wen;
  logic [15:1] waddr;
  logic [15:0] wdata;

  mem_responder #(.DEPTH(256), .INIT_FILE("")) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr0 (raddr0),
    .rdata0 (rdata0),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .wen    (wen),
    .waddr  (waddr),
    .wdata  (wdata)
  );

  typedef struct {
    int unsigned due;
    int unsigned port;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so expectations can name the edge they are due after.
  always @(posedge clk) cyc++;

  // Monitor: compare every expectation whose due edge has passed.
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].due <= cyc) begin
      exp_t        e;
      logic [15:0] act;
      e   = q.pop_front();
      act = (e.port == 1) ? rdata1 : rdata0;
      checks++;
      if (e.due != cyc) begin
        errors++;
        $display("FAIL %s port%0d: checked at edge %0d, required edge %0d", e.name, e.port, cyc, e.due);
      end else if (act !== e.exp) begin
        errors++;
        $display("FAIL %s port%0d: got %h, expected %h", e.name, e.port, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned port, input logic [15:0] exp,
                      input int unsigned lat, input string name);
    exp_t e;
    e.due  = cyc + lat;
    e.port = port;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:1] a, input logic [15:0] d);
    wen   = 1'b1;
    waddr = a;
    wdata = d;
    step();
    wen   = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    wen    = 1'b0;
    waddr  = '0;
    wdata  = '0;
    raddr0 = '0;
    raddr1 = '0;

    // Reset state.
    step();
    step();
    chk("reset_rdata0", rdata0, 16'h0000);
    chk("reset_rdata1", rdata1, 16'h0000);
    rst_n = 1'b1;

    // Latency: previous address still shown one edge after the switch.
    wr(15'h0000, 16'h0BAD);
    wr(15'h0010, 16'hBEEF);
    raddr0 = 15'h0010;
    push(0, 16'h0BAD, 1, "latency_early");
    push(0, 16'hBEEF, 2, "latency_2edge");
    step();
    step();

    // Write-first bypass on port 1, then the array itself holds the new word.
    wr(15'h0020, 16'h1111);
    raddr1 = 15'h0020;
    push(1, 16'h2222, 2, "bypass");
    step();
    wen = 1'b1; waddr = 15'h0020; wdata = 16'h2222;
    push(1, 16'h2222, 2, "bypass_hold");
    step();
    wen = 1'b0;
    step();

    // Write on the edge stage A samples is visible to that read.
    raddr0 = 15'h0030;
    wen = 1'b1; waddr = 15'h0030; wdata = 16'h3333;
    push(0, 16'h3333, 2, "write_same_edge");
    step();
    wen = 1'b0;
    step();

    // Dual-port streaming over a ramp image (word i = i*3).
    for (int i = 0; i < 8; i++) wr(15'(i), 16'(i * 3));
    for (int i = 0; i < 8; i++) begin
      raddr0 = 15'(i);
      raddr1 = 15'(i);
      push(0, 16'(i * 3), 2, $sformatf("stream0_%0d", i));
      push(1, 16'(i * 3), 2, $sformatf("stream1_%0d", i));
      step();
    end
    step();

    // Address wrap with DEPTH=256 on both write and read side.
    wr(15'h0105, 16'hA5A5);
    raddr0 = 15'h0005;
    raddr1 = 15'h0205;
    push(0, 16'hA5A5, 2, "wrap_rd0");
    push(1, 16'hA5A5, 2, "wrap_rd1");
    step();
    step();

    // Same address on both ports, bypassed by a write on the next edge.
    wr(15'h0040, 16'h4444);
    raddr0 = 15'h0040;
    raddr1 = 15'h0040;
    push(0, 16'h7777, 2, "same_addr0");
    push(1, 16'h7777, 2, "same_addr1");
    step();
    wr(15'h0040, 16'h7777);

    // Bypass compare uses the wrapped write address.
    wr(15'h0041, 16'h4141);
    raddr0 = 15'h0041;
    push(0, 16'h5151, 2, "wrap_bypass");
    step();
    wr(15'h0141, 16'h5151);

    // Reset mid-stream with reads in flight.
    wr(15'h0000, 16'h0BAD);
    wr(15'h0050, 16'h5050);
    raddr0 = 15'h0050;
    raddr1 = 15'h0050;
    push(0, 16'h5050, 2, "pre_reset0");
    push(1, 16'h5050, 2, "pre_reset1");
    step();
    step();
    step();
    rst_n = 1'b0;
    #2;
    chk("async_reset_rdata0", rdata0, 16'h0000);
    chk("async_reset_rdata1", rdata1, 16'h0000);
    wen = 1'b1; waddr = 15'h0050; wdata = 16'hDEAD;
    step();
    step();
    chk("in_reset_rdata0", rdata0, 16'h0000);
    chk("in_reset_rdata1", rdata1, 16'h0000);
    wen = 1'b0;
    rst_n = 1'b1;
    push(0, 16'h0BAD, 1, "post_reset_addr0_p0");
    push(1, 16'h0BAD, 1, "post_reset_addr0_p1");
    push(0, 16'h5050, 2, "survive_p0");
    push(1, 16'h5050, 2, "survive_p1");
    step();
    step();

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 8 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
